// File: rtl/rv_fetch_pkg.sv
// rv_fetch_pkg
//   Shared types and constants for the instruction-fetch front end and the
//   pipeline registers that follow it.
//   - NOP_INST         : bubble encoding (addi x0,x0,0)
//   - RESET_PC_DEFAULT : default first fetch address after reset
//   - fetch_state_e    : fetch sequencer states
//   - if_id_t          : contents of an IF/ID-style pipeline register
package rv_fetch_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg
//   IF/ID pipeline register. Priority: bubble > load > hold. With no
//   control asserted it also loads a bubble, so an idle front end drains to
//   NOPs. A bubble keeps the last PC and clears valid. Resets to a bubble.
//   Ports:
//     clk, rst_n           clock, async active-low reset
//     load_i, hold_i,
//     bubble_i             register controls
//     pc_i, inst_i         instruction to capture on load
//     pc_o, inst_o, valid_o  register contents
module if_id_reg #(
  parameter logic [31:0] NOP_INST = rv_fetch_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        hold_i,
  input  logic        bubble_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        valid_o
);
  import rv_fetch_pkg::*;

  if_id_t q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (bubble_i) begin
      q_d.inst  = NOP_INST;
      q_d.valid = 1'b0;
    end else if (load_i) begin
      q_d.pc    = pc_i;
      q_d.inst  = inst_i;
      q_d.valid = 1'b1;
    end else if (!hold_i) begin
      q_d.inst  = NOP_INST;
      q_d.valid = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '{pc: 32'h0, inst: NOP_INST, valid: 1'b0};
    end else begin
      q_q <= q_d;
    end
  end

  assign pc_o    = q_q.pc;
  assign inst_o  = q_q.inst;
  assign valid_o = q_q.valid;

endmodule

// File: rtl/if_id_fetch_unit.sv
// if_id_fetch_unit
//   Pipeline front end: owns the PC, runs a one-outstanding req/gnt/rvalid
//   instruction-memory handshake, parks a returned word in a skid buffer
//   while the pipeline is stalled, and drops responses made stale by an
//   EX-stage redirect.
//   Ports:
//     clk, rst_n                 clock, async active-low reset
//     PCWrite, IF_ID_Write       hazard-unit stall controls (0 = stall)
//     flush, branch_target       EX redirect
//     imem_req, imem_addr        read request / address (= pc)
//     imem_gnt, imem_rvalid,
//     imem_rdata                 memory accept / response
//     id_pc, id_inst, id_valid   IF/ID register contents
module if_id_fetch_unit #(
  parameter logic [31:0] RESET_PC = rv_fetch_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INST = rv_fetch_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PCWrite,
  input  logic        IF_ID_Write,
  input  logic        flush,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid
);
  import rv_fetch_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         kill_q, kill_d;       // outstanding response belongs to a squashed path
  logic [31:0]  skid_pc_q, skid_pc_d;
  logic [31:0]  skid_inst_q, skid_inst_d;

  logic         stall;
  logic         deliver;
  logic [31:0]  deliver_pc;
  logic [31:0]  deliver_inst;

  assign stall = !PCWrite || !IF_ID_Write;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case/if tree can leave it unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_d       = kill_q;
    skid_pc_d    = skid_pc_q;
    skid_inst_d  = skid_inst_q;
    deliver      = 1'b0;
    deliver_pc   = pc_q;
    deliver_inst = imem_rdata;

    unique case (state_q)
      IDLE: state_d = REQ;

      REQ: begin
        if (imem_gnt) begin
          state_d = WAIT;
          // Granted request was for the old path; its data must be dropped.
          if (flush) kill_d = 1'b1;
        end
      end

      WAIT: begin
        if (imem_rvalid) begin
          if (kill_q || flush) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else if (!stall) begin
            deliver = 1'b1;
            pc_d    = pc_q + 32'd4;
            state_d = REQ;
          end else begin
            skid_pc_d   = pc_q;
            skid_inst_d = imem_rdata;
            state_d     = HOLD;
          end
        end else if (flush) begin
          kill_d = 1'b1;
        end
      end

      HOLD: begin
        deliver_pc   = skid_pc_q;
        deliver_inst = skid_inst_q;
        if (flush) begin
          state_d = REQ;
        end else if (!stall) begin
          deliver     = 1'b1;
          pc_d        = pc_q + 32'd4;
          skid_pc_d   = 32'h0;
          skid_inst_d = 32'h0;
          state_d     = REQ;
        end
      end

      default: state_d = IDLE;
    endcase

    // Redirect overrides everything else: new PC, empty skid buffer.
    if (flush) begin
      pc_d        = branch_target;
      skid_pc_d   = 32'h0;
      skid_inst_d = 32'h0;
    end
  end

  // NOTE: the skid buffer is reset too: it is a handful of flops, and a
  // defined value keeps the HOLD path free of X after an early flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      kill_q      <= 1'b0;
      skid_pc_q   <= 32'h0;
      skid_inst_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_q      <= kill_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
    end
  end

  assign imem_req  = (state_q == REQ);
  assign imem_addr = pc_q;

  if_id_reg #(
    .NOP_INST (NOP_INST)
  ) u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (deliver),
    .hold_i   (stall),
    .bubble_i (flush),
    .pc_i     (deliver_pc),
    .inst_i   (deliver_inst),
    .pc_o     (id_pc),
    .inst_o   (id_inst),
    .valid_o  (id_valid)
  );

endmodule

// File: tb/tb_if_id_fetch_unit.sv
// tb_if_id_fetch_unit
//   Directed stimulus for if_id_fetch_unit with a scoreboard: the expected
//   {pc, inst} is queued when a non-stale response is driven, and popped by a
//   monitor whenever the IF/ID register presents a new valid instruction.
module tb_if_id_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        PCWrite = 1'b1;
  logic        IF_ID_Write = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;

  if_id_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .PCWrite       (PCWrite),
    .IF_ID_Write   (IF_ID_Write),
    .flush         (flush),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .id_pc         (id_pc),
    .id_inst       (id_inst),
    .id_valid      (id_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Scoreboard monitor: a new instruction is a valid IF/ID that differs from
  // what was presented the cycle before.
  logic [31:0] prev_pc = 32'h0;
  logic [31:0] prev_inst = 32'h0;
  logic        prev_valid = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (id_valid && (!prev_valid || id_pc !== prev_pc || id_inst !== prev_inst)) begin
        check("sb_has_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          logic [63:0] e;
          e = exp_q.pop_front();
          check("sb_pc", id_pc, e[63:32]);
          check("sb_inst", id_inst, e[31:0]);
        end
      end
      prev_valid = id_valid;
      prev_pc    = id_pc;
      prev_inst  = id_inst;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One zero-wait fetch starting in REQ: gnt now, rvalid next cycle.
  task automatic fetch(input logic [31:0] data);
    logic [31:0] a;
    check("req_before_gnt", 32'(imem_req), 32'd1);
    a = imem_addr;
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    check("req_low_in_wait", 32'(imem_req), 32'd0);
    check("bubble_after_gnt", 32'(id_valid), 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    exp_q.push_back({a, data});
    tick();
    imem_rvalid = 1'b0;
    check("deliver_valid", 32'(id_valid), 32'd1);
    check("deliver_pc", id_pc, a);
    check("deliver_inst", id_inst, data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset / boot
    repeat (3) @(posedge clk);
    #1;
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_id_inst", id_inst, NOP);
    check("rst_id_pc", id_pc, 32'h0);
    check("rst_req", 32'(imem_req), 32'd0);
    rst_n = 1'b1;
    tick();
    check("boot_req", 32'(imem_req), 32'd1);
    check("boot_addr", imem_addr, 32'h0);
    fetch(32'h0050_0093);

    // Stream: 4, 8, C
    fetch(32'h0040_0113);
    fetch(32'h0030_0193);
    fetch(32'h0020_0213);

    // Stall into skid at pc 0x10
    check("stall_addr", imem_addr, 32'h10);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0002_A303;
    PCWrite     = 1'b0;
    IF_ID_Write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      imem_rvalid = 1'b0;
      check("stall_hold_pc", id_pc, 32'hC);
      check("stall_hold_inst", id_inst, NOP);
      check("stall_hold_valid", 32'(id_valid), 32'd0);
      check("stall_no_req", 32'(imem_req), 32'd0);
    end
    PCWrite     = 1'b1;
    IF_ID_Write = 1'b1;
    exp_q.push_back({32'h10, 32'h0002_A303});
    tick();
    check("skid_inst", id_inst, 32'h0002_A303);
    check("skid_pc", id_pc, 32'h10);
    check("skid_valid", 32'(id_valid), 32'd1);
    check("skid_next_addr", imem_addr, 32'h14);

    // Flush during WAIT
    fetch(32'h0010_0293);
    fetch(32'h0010_0313);
    fetch(32'h0010_0393);
    check("fw_addr", imem_addr, 32'h20);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    flush = 1'b1;
    branch_target = 32'h100;
    tick();
    flush = 1'b0;
    check("fw_valid", 32'(id_valid), 32'd0);
    check("fw_inst", id_inst, NOP);
    check("fw_no_req", 32'(imem_req), 32'd0);
    tick();
    check("fw_still_wait", 32'(imem_req), 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    check("fw_discard_valid", 32'(id_valid), 32'd0);
    check("fw_req", 32'(imem_req), 32'd1);
    check("fw_addr_target", imem_addr, 32'h100);

    // Flush and stall together
    fetch(32'h0000_0433);
    flush = 1'b1;
    branch_target = 32'h200;
    PCWrite = 1'b0;
    IF_ID_Write = 1'b0;
    tick();
    flush = 1'b0;
    PCWrite = 1'b1;
    IF_ID_Write = 1'b1;
    check("fs_valid", 32'(id_valid), 32'd0);
    check("fs_inst", id_inst, NOP);
    check("fs_pc", id_pc, 32'h100);
    check("fs_req", 32'(imem_req), 32'd1);
    check("fs_addr", imem_addr, 32'h200);

    // Flush in the same cycle as gnt
    imem_gnt = 1'b1;
    flush = 1'b1;
    branch_target = 32'h300;
    tick();
    imem_gnt = 1'b0;
    flush = 1'b0;
    check("fg_wait", 32'(imem_req), 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBADC_0DE0;
    tick();
    imem_rvalid = 1'b0;
    check("fg_discard_valid", 32'(id_valid), 32'd0);
    check("fg_req", 32'(imem_req), 32'd1);
    check("fg_addr", imem_addr, 32'h300);

    // Reset while in WAIT, late rvalid ignored
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    check("rw_in_wait", 32'(imem_req), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rw_async_addr", imem_addr, 32'h0);
    check("rw_async_req", 32'(imem_req), 32'd0);
    check("rw_async_valid", 32'(id_valid), 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1234_5678;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    imem_rvalid = 1'b0;
    check("rw_req", 32'(imem_req), 32'd1);
    check("rw_addr", imem_addr, 32'h0);
    check("rw_valid", 32'(id_valid), 32'd0);
    fetch(32'h0010_0073);

    // Wrap: flush to 0xFFFF_FFFC, next fetch at 0
    flush = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    tick();
    flush = 1'b0;
    check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    fetch(32'h00A0_0513);
    check("wrap_addr_zero", imem_addr, 32'h0);
    check("wrap_req", 32'(imem_req), 32'd1);

    tick();
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/if_id_fetch_unit.md
Name: if_id_fetch_unit

Overview:
- Front end of the 5-stage RISC-V pipeline: owns the PC, issues instruction-memory reads and fills the IF/ID pipeline register.
- Consumes the hazard unit's stall outputs (PCWrite, IF_ID_Write) and the EX-stage redirect (flush/branch_target).
- Handles a one-outstanding req/gnt/rvalid instruction-memory handshake, holds a fetched word in a skid buffer during stalls, and discards stale responses after redirects.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INST, 32'h0000_0013, bubble encoding (addi x0,x0,0).

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- PCWrite  in  1  from hazard unit; 0 = stall PC
- IF_ID_Write  in  1  from hazard unit; 0 = hold IF/ID
- flush  in  1  taken branch/jump resolved in EX
- branch_target  in  32  redirect PC, valid when flush=1
- imem_req  out  1  read request
- imem_addr  out  32  read address (= pc)
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  read data valid
- imem_rdata  in  32  instruction word
- id_pc  out  32  IF/ID PC
- id_inst  out  32  IF/ID instruction
- id_valid  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (async assert, sync deassert use): pc=RESET_PC, id_pc=0, id_inst=NOP_INST, id_valid=0, imem_req=0, kill=0, skid empty, state=IDLE.
- stall = !PCWrite | !IF_ID_Write; both deasserted together in practice, either alone stalls.
- States: IDLE, REQ, WAIT, HOLD.
- IDLE -> REQ unconditionally on the first clock after reset release.
- REQ:
  - imem_req=1, imem_addr=pc.
  - Address stays stable while req && !gnt, except after a flush.
  - gnt -> WAIT.
- WAIT:
  - imem_req=0.
  - On rvalid with kill=1: discard the data, clear kill, go to REQ.
  - On rvalid with kill=0 and !stall: IF/ID <= {pc, rdata, valid=1}; pc <= pc+4; go to REQ.
  - On rvalid with kill=0 and stall: skid <= {pc, rdata}; go to HOLD.
- HOLD:
  - imem_req=0.
  - When !stall: IF/ID <= skid, valid=1; pc <= pc+4; go to REQ.
- IF/ID update when no instruction is delivered this cycle:
  - !stall: load a bubble (inst=NOP_INST, valid=0, pc unchanged).
  - stall: hold all IF/ID fields.
- Flush has highest priority over stall and delivery:
  - IF/ID <= bubble; pc <= branch_target; skid cleared.
  - REQ without gnt: stay in REQ; the next cycle's address is branch_target.
  - REQ with gnt: go to WAIT with kill=1.
  - WAIT without rvalid: set kill=1.
  - WAIT with rvalid: discard the data, go to REQ.
  - HOLD: go to REQ.
  - IDLE: only the pc is updated.
- PC arithmetic: 32-bit, wraps modulo 2^32 (0xFFFF_FFFC+4 = 0). Bits [1:0] are not checked.
- Latency: gnt at cycle t, rvalid at t+k (k>=1), id_* valid at t+k+1. Peak throughput is one instruction per 2 cycles.
- rvalid outside WAIT is a protocol error and is ignored.

Decomposition:
- Shared package rv_fetch_pkg:
  - NOP_INST constant
  - fetch state enum {IDLE, REQ, WAIT, HOLD}
  - RESET_PC default
  - if_id_t struct {pc, inst, valid}
- Sub-module if_id_reg: IF/ID register with load, hold and bubble inputs, reset to bubble. Used later by the ID/EX stage as a pattern.

Test Plan:
- Reset/boot:
  - Stimulus: rst_n low 3 cycles, then high; imem grants immediately, rvalid next cycle with 0x00500093.
  - Required: imem_req rises 1 cycle after reset release with addr 0x0; id_inst=0x00500093, id_pc=0, id_valid=1 two cycles after gnt.
- Stream:
  - Stimulus: 4 fetches with zero-wait memory.
  - Required: id_pc sequence 0,4,8,C; id_valid alternates 1/0 (bubble between instructions).
- Stall into skid:
  - Stimulus: PCWrite=IF_ID_Write=0 for 3 cycles, asserted in the cycle rvalid returns 0x0002A303 at pc 0x10.
  - Required: IF/ID holds its prior contents for all 3 cycles, no imem_req; 1 cycle after release, id_inst=0x0002A303, id_pc=0x10; next imem_addr=0x14.
- Flush during WAIT:
  - Stimulus: gnt at pc 0x20, flush with target 0x100 the next cycle, rvalid 2 cycles later.
  - Required: id_valid=0 after the flush, returned data discarded, next imem_addr=0x100.
- Flush and stall together:
  - Stimulus: flush=1, PCWrite=0, IF_ID_Write=0 in the same cycle.
  - Required: IF/ID becomes NOP_INST/valid=0, pc=target.
- Reset mid-operation and wrap:
  - Stimulus (a): rst_n low while in WAIT.
  - Required (a): immediate return to IDLE; a late rvalid is ignored; first fetch at RESET_PC.
  - Stimulus (b): flush to 0xFFFF_FFFC.
  - Required (b): the next fetch after it is addr 0x0.
